// File: rtl/serializador_debug.sv
// serializador_debug: snapshots cycle count and PC, then streams header/count/PC/checksum bytes to a UART TX
module serializador_debug #(
  parameter int CONTADOR_LENGTH = 11,
  parameter int PC_LENGTH = 32,
  parameter int DATA_LENGTH = 8,
  parameter logic [DATA_LENGTH-1:0] HEADER = 8'hA5
) (
  input  logic                       i_clock,
  input  logic                       i_soft_reset,
  input  logic                       i_start,
  input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
  input  logic [PC_LENGTH-1:0]       i_pc,
  input  logic                       i_tx_done,
  output logic [DATA_LENGTH-1:0]     o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int NB_CUENTA = (CONTADOR_LENGTH + DATA_LENGTH - 1) / DATA_LENGTH;
  localparam int NB_PC = (PC_LENGTH + DATA_LENGTH - 1) / DATA_LENGTH;
  localparam int TOTAL = NB_CUENTA + NB_PC + 2;
  localparam int IW = $clog2(TOTAL);
  localparam int CW = NB_CUENTA * DATA_LENGTH;
  localparam int PW = NB_PC * DATA_LENGTH;
  localparam int SW = CW + PW;
  localparam int FW = SW + DATA_LENGTH;
  localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_LENGTH-1:0] chk_q, chk_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [FW-1:0] frame_sh;
  logic [DATA_LENGTH-1:0] cur_byte;
  logic is_last;
  assign is_last = idx_q == LAST;
  assign frame_sh = {HEADER, snap_q} << (int'(idx_q) * DATA_LENGTH);
  assign cur_byte = is_last ? chk_q : frame_sh[FW-1 -: DATA_LENGTH];
  assign o_tx_start = state_q == LOAD;
  assign o_tx_data = (state_q == LOAD) ? cur_byte : data_q;
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  // Next-state logic: accept a frame in IDLE, emit one byte per LOAD, advance on tx_done in WAIT
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    idx_d = idx_q;
    chk_d = chk_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (i_start) begin
        snap_d = {CW'(i_cuenta), PW'(i_pc)};
        idx_d = '0;
        chk_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        data_d = cur_byte;
        chk_d = is_last ? chk_q : chk_q ^ cur_byte;
        state_d = WAIT;
      end
      WAIT: if (i_tx_done) begin
        state_d = is_last ? DONE : LOAD;
        idx_d = is_last ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous soft reset clearing everything
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state_q <= IDLE;
      snap_q <= '0;
      idx_q <= '0;
      chk_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_serializador_debug.sv
// tb_serializador_debug: randomized frame checks against a byte-level frame model with a UART responder
module tb_serializador_debug;
  logic i_clock = 1'b0;
  logic i_soft_reset = 1'b1;
  logic i_start = 1'b0;
  logic i_tx_done = 1'b0;
  logic [10:0] i_cuenta = '0;
  logic [31:0] i_pc = '0;
  logic [7:0] o_tx_data;
  logic o_tx_start, o_busy, o_done;
  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  int n_done, first_cyc;
  bit busy_after, timeout;
  typedef logic [7:0] frame_t [8];

  always #5 i_clock = ~i_clock;

  serializador_debug dut (
    .i_clock(i_clock), .i_soft_reset(i_soft_reset), .i_start(i_start),
    .i_cuenta(i_cuenta), .i_pc(i_pc), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy), .o_done(o_done)
  );

  function automatic frame_t model(input logic [10:0] c, input logic [31:0] p);
    frame_t f;
    int unsigned cz;
    cz = c;
    f[0] = 8'hA5;
    f[1] = 8'((cz / 256) % 256);
    f[2] = 8'(cz % 256);
    f[3] = 8'(p / 32'h0100_0000);
    f[4] = 8'((p / 32'h0001_0000) % 256);
    f[5] = 8'((p / 32'h0000_0100) % 256);
    f[6] = 8'(p % 256);
    f[7] = 8'h00;
    for (int i = 0; i < 7; i++) f[7] = f[7] ^ f[i];
    return f;
  endfunction

  // UART responder: records bytes, answers tx_done gap cycles after each start.
  // mode 1: stray tx_done in every LOAD plus stray start/input change in WAIT of byte ev_byte.
  // mode 2: return while in WAIT of byte ev_byte.
  task automatic serve_frame(input int gap, input int mode, input int ev_byte, input bit restart);
    int cd = -1;
    bit prev_done = 0;
    int extra = -1;
    got.delete();
    n_done = 0; busy_after = 1; timeout = 1; first_cyc = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge i_clock);
      i_start = 0;
      i_tx_done = 0;
      if (prev_done) begin
        busy_after = o_busy;
        prev_done = 0;
        if (restart) begin
          i_start = 1;
          timeout = 0;
          return;
        end
      end
      if (o_done) begin
        n_done++;
        prev_done = 1;
        if (extra < 0) extra = 6;
      end
      if (o_tx_start) begin
        if (first_cyc < 0) first_cyc = cyc;
        got.push_back(o_tx_data);
        cd = gap;
        if (mode == 1) i_tx_done = 1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) i_tx_done = 1;
      end
      if (cd == 2 && got.size() == ev_byte + 1) begin
        if (mode == 1) begin
          i_start = 1;
          i_cuenta = 11'h001;
          i_pc = 32'h1234_5678;
        end
        if (mode == 2) begin
          timeout = 0;
          return;
        end
      end
      if (extra > 0) begin
        extra--;
        if (extra == 0) begin
          timeout = 0;
          return;
        end
      end
    end
  endtask

  task automatic launch(input logic [10:0] c, input logic [31:0] p);
    @(negedge i_clock);
    i_cuenta = c;
    i_pc = p;
    i_start = 1;
  endtask

  task automatic test_reset();
    i_soft_reset = 1;
    i_start = 0;
    i_tx_done = 0;
    repeat (2) @(negedge i_clock);
    i_soft_reset = 0;
    checks++; if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_tx_data); end
    checks++; if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", o_tx_start); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
  endtask

  task automatic test_basic();
    logic [7:0] req [8] = '{8'hA5, 8'h05, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h40, 8'h43};
    launch(11'h5A3, 32'h0000_0040);
    serve_frame(5, 0, -1, 0);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timeout); end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== req[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], req[i]); end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_after); end
    checks++; if (first_cyc != 0) begin failures++; $display("FAIL basic_latency got=%0d exp=0", first_cyc); end
    checks++; if (o_tx_data !== 8'h43) begin failures++; $display("FAIL basic_idle_hold got=%h exp=43", o_tx_data); end
  endtask

  task automatic test_saturated();
    logic [7:0] req [8] = '{8'hA5, 8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5D};
    launch(11'h7FF, 32'hFFFF_FFFF);
    serve_frame(4, 0, -1, 0);
    checks++; if (timeout !== 1'b0 || got.size() != 8) begin failures++; $display("FAIL sat_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== req[i]) begin failures++; $display("FAIL sat_byte%0d got=%h exp=%h", i, got[i], req[i]); end
    end
    if (got.size() > 1) begin
      checks++; if (got[1][7:3] !== 5'b0) begin failures++; $display("FAIL sat_upper got=%b exp=00000", got[1][7:3]); end
    end
  endtask

  task automatic test_snapshot();
    frame_t exp;
    exp = model(11'h2C7, 32'hDEAD_BEEF);
    launch(11'h2C7, 32'hDEAD_BEEF);
    serve_frame(6, 1, 3, 0);
    checks++; if (timeout !== 1'b0 || got.size() != 8) begin failures++; $display("FAIL snap_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL snap_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    checks++; if (n_done != 1 || busy_after !== 1'b0) begin failures++; $display("FAIL snap_no_second got=done%0d/busy%b exp=done1/busy0", n_done, busy_after); end
  endtask

  task automatic test_reset_mid();
    frame_t exp;
    int starts = 0;
    int busys = 0;
    launch(11'h123, 32'h1357_9BDF);
    serve_frame(5, 2, 4, 0);
    checks++; if (timeout !== 1'b0 || got.size() != 5) begin failures++; $display("FAIL rmid_reach got=%0d exp=5", got.size()); end
    i_soft_reset = 1;
    @(negedge i_clock);
    i_soft_reset = 0;
    checks++; if ({o_tx_data, o_tx_start, o_busy, o_done} !== 11'b0) begin failures++; $display("FAIL rmid_outputs got=%h/%b%b%b exp=00/000", o_tx_data, o_tx_start, o_busy, o_done); end
    i_tx_done = 1;
    @(negedge i_clock);
    i_tx_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_tx_start) starts++;
      if (o_busy) busys++;
      @(negedge i_clock);
    end
    checks++; if (starts != 0 || busys != 0) begin failures++; $display("FAIL rmid_quiet got=start%0d/busy%0d exp=0/0", starts, busys); end
    exp = model(11'h456, 32'hCAFE_0001);
    i_cuenta = 11'h456;
    i_pc = 32'hCAFE_0001;
    i_start = 1;
    serve_frame(3, 0, -1, 0);
    checks++; if (timeout !== 1'b0 || got.size() != 8) begin failures++; $display("FAIL rmid_new_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    frame_t exp;
    logic [10:0] c;
    logic [31:0] p;
    for (int n = 0; n < 6; n++) begin
      c = 11'($urandom);
      p = $urandom;
      exp = model(c, p);
      launch(c, p);
      if (n % 2 == 1) i_tx_done = 1;
      serve_frame(int'($urandom_range(3, 8)), 0, -1, 0);
      checks++; if (timeout !== 1'b0 || got.size() != 8 || n_done != 1) begin failures++; $display("FAIL rand%0d_shape got=%0d/%0d exp=8/1", n, got.size(), n_done); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
        checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", n, i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t exp;
    launch(11'h0F0, 32'h8000_0001);
    serve_frame(3, 0, -1, 1);
    checks++; if (timeout !== 1'b0 || got.size() != 8 || busy_after !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=8/0", got.size(), busy_after); end
    i_cuenta = 11'h00A;
    i_pc = 32'h0000_FFFF;
    exp = model(11'h00A, 32'h0000_FFFF);
    serve_frame(4, 0, -1, 0);
    checks++; if (first_cyc != 0) begin failures++; $display("FAIL b2b_latency got=%0d exp=0", first_cyc); end
    checks++; if (timeout !== 1'b0 || got.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturated();
    test_snapshot();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serializador_debug.md
Name: serializador_debug

Overview:
- Downstream consumer of the MIPS cycle counter output, inside the debug unit.
- On a start pulse it snapshots the cycle count and the current PC, then builds a fixed frame: header, count, PC, checksum.
- It hands the frame byte by byte to the UART transmitter over a start/done handshake so the host PC can read execution statistics after a halt or step.

Parameters:
- CONTADOR_LENGTH, 11, width of the cycle count input.
- PC_LENGTH, 32, width of the PC input.
- DATA_LENGTH, 8, UART byte width.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_soft_reset  in  1  synchronous reset, active-high.
- i_start  in  1  request to send one frame. Sampled only in IDLE.
- i_cuenta  in  CONTADOR_LENGTH  cycle count from the counter stage.
- i_pc  in  PC_LENGTH  program counter value.
- i_tx_done  in  1  one-cycle pulse from the UART TX when the current byte has been sent.
- o_tx_data  out  DATA_LENGTH  byte to transmit.
- o_tx_start  out  1  one-cycle pulse telling the UART TX to start sending o_tx_data.
- o_busy  out  1  high from the cycle after i_start is accepted until return to IDLE.
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset:
  - i_soft_reset high at a rising edge forces state IDLE.
  - All outputs go to 0 and the snapshot registers, byte index and checksum are cleared.
  - Reset overrides every other input, including mid-frame. No o_tx_start is issued after a reset until a new i_start.
- Frame length: NB_CUENTA = ceil(CONTADOR_LENGTH/8) = 2 and NB_PC = ceil(PC_LENGTH/8) = 4 by default. Total bytes = 1 + NB_CUENTA + NB_PC + 1 = 8.
- Byte order:
  - HEADER first.
  - Count MSB-first, zero-extended to NB_CUENTA*8 bits.
  - PC MSB-first, zero-extended to NB_PC*8 bits.
  - Checksum last.
- Checksum: XOR of every preceding byte, including HEADER.
- States:
  - IDLE: i_start high at edge N -> snapshot i_cuenta and i_pc, set byte index 0, load checksum register with 0, go to LOAD.
  - LOAD: for one cycle drive o_tx_data = current byte and o_tx_start = 1. Fold the byte into the checksum. Go to WAIT. For the final byte, o_tx_data is the accumulated checksum; the checksum is not folded further.
  - WAIT: hold o_tx_data stable with o_tx_start = 0 until i_tx_done = 1.
    - On i_tx_done, if this was the last byte, go to DONE.
    - Otherwise increment the byte index and go to LOAD.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Latency and timing:
  - i_start at edge N gives o_busy = 1 and o_tx_start = 1 (header) in cycle N+1.
  - i_tx_done sampled at edge M gives the next byte's o_tx_start in cycle M+1.
- o_busy is high in LOAD, WAIT and DONE, and low in IDLE.
- Simultaneous and stray inputs:
  - i_start while not in IDLE is ignored; there is no queuing.
  - i_tx_done outside WAIT is ignored, including a pulse in the same cycle as o_tx_start.
  - i_start and i_tx_done high together in IDLE: the frame starts normally.
- The snapshot is frozen for the whole frame. Changes on i_cuenta or i_pc mid-frame do not affect bytes already queued or bytes to come.
- o_tx_data keeps its last value in IDLE. Only reset clears it to 0.

Test Plan:
- Reset check: assert i_soft_reset for 2 cycles -> o_tx_data = 0, o_tx_start = 0, o_busy = 0, o_done = 0.
- Basic frame: i_cuenta = 11'h5A3, i_pc = 32'h0000_0040, i_start pulse, UART model answers i_tx_done 5 cycles after each o_tx_start.
  - Required bytes: A5, 05, A3, 00, 00, 00, 40, 43.
  - Exactly 8 o_tx_start pulses, then a single o_done.
  - o_busy drops the cycle after o_done.
- Saturated values: i_cuenta = 11'h7FF, i_pc = 32'hFFFF_FFFF.
  - Required bytes: A5, 07, FF, FF, FF, FF, FF, 5D.
  - The upper 5 bits of the count byte must be zero.
- Snapshot and stray inputs: change i_cuenta to 11'h001 and pulse i_start during byte 3's WAIT.
  - The frame must still carry the original values.
  - No second frame may start.
  - A stray i_tx_done during LOAD must not advance the byte index.
- Reset mid-frame: assert i_soft_reset while in WAIT on byte 4.
  - Next cycle: IDLE with all outputs 0.
  - A later i_tx_done produces nothing.
  - A new i_start sends a complete 8-byte frame starting with A5.
- Back-to-back: pulse i_start in the cycle after o_done -> it is accepted and o_tx_start (header) follows one cycle later.
